// File: rtl/sb_ram_reader_pkg.sv
// sb_ram_reader_pkg: shared defaults and FSM encoding for the sample RAM reader.
package sb_ram_reader_pkg;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, FIN = 2'd3} state_t;
endpackage

// File: rtl/sb_ram_reader_if.sv
// sb_ram_reader_if: valid/ready sample stream between the reader and the host transfer logic.
interface sb_ram_reader_if import sb_ram_reader_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  modport master (output m_data, m_valid, input m_ready);
  modport slave (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/sb_ram_reader_skid.sv
// sb_skid_buffer: 2-entry valid/ready FIFO; the producer must never push into a full buffer.
module sb_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);
  logic [DATA_WIDTH-1:0] d0, d1;
  logic pop;
  assign pop = m_valid & m_ready;
  assign m_valid = count != 2'd0;
  assign m_data = d0;
  // d0 is the head and only changes on a pop or when filling an empty buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      d0 <= '0;
      d1 <= '0;
      count <= '0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) d0 <= (count == 2'd2) ? d1 : data_in;
      else if (push && count == 2'd0) d0 <= data_in;
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) d1 <= data_in;
    end
endmodule

// File: rtl/sb_ram_reader.sv
// sb_ram_reader: drains a circular sample RAM into a valid/ready stream, wrapping modulo depth.
// SB_RAM_READER_DECIM_EN adds a decim input that strides the read pointer by decim+1.
module sb_ram_reader import sb_ram_reader_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_samples,
`ifdef SB_RAM_READER_DECIM_EN
  input  logic [ADDR_WIDTH-1:0] decim,
`endif
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  sb_ram_reader_if.master       m
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, step;
  logic [ADDR_WIDTH:0] rem;
  logic [1:0] count, occ;
  logic inflight, issue, pop, accept;
  assign accept = state == IDLE && start;
  assign pop = m.m_valid & m.m_ready;
  // occupancy after this cycle's pop lets a read issue every cycle at full rate without overflow
  assign occ = count - 2'(pop) + 2'(inflight);
  assign issue = state == RUN && occ < 2'd2;
  assign raddr = ptr;
  assign busy = state == RUN || state == FLUSH;
`ifdef SB_RAM_READER_DECIM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) step <= ADDR_WIDTH'(1);
    else if (accept) step <= decim + 1'b1;
`else
  assign step = ADDR_WIDTH'(1);
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (num_samples == '0) ? FIN : RUN;
      RUN: if (issue && rem == (ADDR_WIDTH+1)'(1)) state_n = FLUSH;
      FLUSH: if (!inflight && count == 2'd0) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      rem <= '0;
      inflight <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= issue;
      done <= state == FIN;
      if (accept) begin
        ptr <= start_addr;
        rem <= num_samples;
      end else if (issue) begin
        ptr <= ptr + step;
        rem <= rem - 1'b1;
      end
    end
  sb_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .data_in(rdata),
    .count(count),
    .m_data(m.m_data),
    .m_valid(m.m_valid),
    .m_ready(m.m_ready)
  );
endmodule

// File: tb/tb_sb_ram_reader.sv
// tb_sb_ram_reader: table-driven and randomized checks of sb_ram_reader against a queue-based model.
module tb_sb_ram_reader;
  import sb_ram_reader_pkg::*;
  localparam int AW = 9, DW = 8, DEPTH = 512;
  logic clk = 0, rst = 1, start = 0;
  logic [AW-1:0] start_addr = '0, raddr;
  logic [AW:0] num_samples = '0;
  logic [DW-1:0] rdata, mem [DEPTH];
  logic busy, done;
`ifdef SB_RAM_READER_DECIM_EN
  logic [AW-1:0] decim = '0;
`endif
  sb_ram_reader_if #(.DATA_WIDTH(DW)) m ();
  sb_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_samples(num_samples),
`ifdef SB_RAM_READER_DECIM_EN
    .decim(decim),
`endif
    .raddr(raddr), .rdata(rdata), .busy(busy), .done(done), .m(m)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[raddr];

  int n_checks = 0, n_fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] got_q [$];
  int done_cnt = 0, issued = 0, max_out = 0;
  logic pv = 0, pr = 0, pb = 0;
  logic [DW-1:0] pd = '0;
  logic [AW-1:0] pa = '0;
  always @(negedge clk) begin
    if (pv && !pr && rst) begin
      chk("hold_valid", m.m_valid, 1);
      chk("hold_data", m.m_data, pd);
    end
    if (pb && busy && raddr != pa) issued++;
    if (m.m_valid && m.m_ready) got_q.push_back(m.m_data);
    if (done) done_cnt++;
    if (issued - got_q.size() > max_out) max_out = issued - got_q.size();
    pv = m.m_valid; pr = m.m_ready; pd = m.m_data; pb = busy; pa = raddr;
  end

  task automatic xfer(input logic [AW-1:0] a, input int n, input int mode, input int step, input bit second);
    logic [DW-1:0] exp_q [$];
    int stall = 0, cyc = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(a) + i * step) % DEPTH]);
    got_q.delete(); done_cnt = 0; issued = 0; max_out = 0;
    @(posedge clk); #1;
    start = 1; start_addr = a; num_samples = (AW+1)'(n);
`ifdef SB_RAM_READER_DECIM_EN
    decim = AW'(step - 1);
`endif
    @(posedge clk); #1;
    start = 0; start_addr = AW'($urandom); num_samples = (AW+1)'($urandom);
    while (!(done_cnt > 0 && !busy) && cyc < 3000) begin
      if (mode == 0) m.m_ready = 1;
      else if (mode == 1) begin
        if (stall > 0) begin m.m_ready = 0; stall--; end
        else if ($urandom_range(0, 5) == 0) begin m.m_ready = 0; stall = 4; end
        else m.m_ready = 1'($urandom_range(0, 1));
      end else m.m_ready = 1'($urandom_range(0, 1));
      if (second) begin
        start = (cyc == 2);
        start_addr = 9'h100; num_samples = 10'd3;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; m.m_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("timeout", cyc < 3000, 1);
    chk("sample_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk($sformatf("data[%0d]", i), got_q[i], exp_q[i]);
    chk("done_pulses", done_cnt, 1);
    chk("busy_end", busy, 0);
    chk("outstanding", max_out <= 2, 1);
  endtask

  typedef struct {logic [AW-1:0] addr; int n; int mode; logic [DW-1:0] first, last;} vec_t;
  vec_t tbl [6];

  initial begin
    tbl = '{'{9'h010, 4, 0, 8'h10, 8'h13}, '{9'h1FE, 4, 0, 8'hFE, 8'h01},
            '{9'h020, 16, 1, 8'h20, 8'h2F}, '{9'h100, 512, 0, 8'h00, 8'hFF},
            '{9'h0F0, 16, 2, 8'hF0, 8'hFF}, '{9'h1FF, 1, 1, 8'hFF, 8'hFF}};
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    m.m_ready = 1;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", m.m_valid, 0);
    chk("rst_data", m.m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1;
    // latency: start cycle, latch cycle, read cycle, then data
    @(posedge clk); #1;
    start = 1; start_addr = 9'h010; num_samples = 10'd4;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("lat_busy", busy, 1);
    chk("lat_valid_c1", m.m_valid, 0);
    @(negedge clk);
    chk("lat_valid_c2", m.m_valid, 0);
    @(negedge clk);
    chk("lat_valid_c3", m.m_valid, 1);
    chk("lat_data_c3", m.m_data, 8'h10);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("lat_stream", {m.m_valid, m.m_data}, {1'b1, 8'h10 + 8'(i)});
    end
    repeat (10) @(posedge clk);
    // zero-length transfer
    @(posedge clk); #1;
    start = 1; start_addr = 9'h055; num_samples = 10'd0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("zero_done_c1", done, 0);
    chk("zero_busy_c1", busy, 0);
    @(negedge clk);
    chk("zero_done_c2", done, 1);
    chk("zero_valid_c2", m.m_valid, 0);
    @(negedge clk);
    chk("zero_done_c3", done, 0);
    for (int t = 0; t < 6; t++) begin
      xfer(tbl[t].addr, tbl[t].n, tbl[t].mode, 1, 0);
      chk("tbl_first", got_q[0], tbl[t].first);
      chk("tbl_last", got_q[got_q.size()-1], tbl[t].last);
    end
    xfer(9'h040, 8, 0, 1, 1);
    // abort after three samples
    got_q.delete(); done_cnt = 0;
    @(posedge clk); #1;
    start = 1; start_addr = 9'h080; num_samples = 10'd10;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 50 && got_q.size() < 3; c++) @(negedge clk);
    chk("abort_reach3", got_q.size(), 3);
    #1 rst = 0;
    #1;
    chk("abort_valid", m.m_valid, 0);
    chk("abort_data", m.m_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_raddr", raddr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt, 0);
    xfer(9'h030, 5, 2, 1, 0);
`ifdef SB_RAM_READER_DECIM_EN
    xfer(9'h000, 4, 0, 4, 0);
    chk("decim_1", got_q[1], 8'h04);
    chk("decim_3", got_q[3], 8'h0C);
`endif
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 8; t++) begin
`ifdef SB_RAM_READER_DECIM_EN
      xfer(AW'($urandom), $urandom_range(1, 40), $urandom_range(0, 2), $urandom_range(1, 6), 0);
`else
      xfer(AW'($urandom), $urandom_range(1, 40), $urandom_range(0, 2), 1, 0);
`endif
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/sb_ram_reader.md
Name: sb_ram_reader

Overview:
- Read-side engine for the dual-clock sample RAM. Drains a circular acquisition buffer through the RAM read port (`raddr`/`dout`, 1-cycle registered read latency) and presents the samples as a valid/ready stream to the host transfer logic.
- Runs entirely in the RAM read-clock domain.
- One start pulse transfers N samples beginning at a given address, wrapping modulo RAM depth.

Parameters:
- ADDR_WIDTH, 9, RAM address width; buffer depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, sample width.

Ports:
- clk  input  1  single clock; drives the RAM `rclk`.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- start_addr  input  ADDR_WIDTH  first RAM address to read.
- num_samples  input  ADDR_WIDTH+1  samples to transfer, 0..2**ADDR_WIDTH.
- raddr  output  ADDR_WIDTH  RAM read address.
- rdata  input  DATA_WIDTH  RAM `dout`; valid one clk after `raddr` is presented.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from consumer.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse after the last sample is accepted by the consumer.

Behaviour:
- Reset (async assert, sync release): state=IDLE; raddr=0; m_valid=0; m_data=0; busy=0; done=0; counters and skid buffer cleared. Asserting reset mid-transfer aborts immediately with no done pulse.
- FSM states:
  - IDLE: on start, latch `start_addr` into the address pointer and `num_samples` into the remaining counter. If num_samples=0, go to FIN; otherwise go to RUN. busy rises the cycle after start.
  - RUN: issue one read per cycle while remaining>0 and credit available. Credit = skid occupancy + reads in flight < 2. Each issue increments the pointer (wraps 2**ADDR_WIDTH-1 -> 0) and decrements remaining. When remaining reaches 0, go to FLUSH.
  - FLUSH: wait until there are no reads in flight and the skid buffer is empty, then go to FIN.
  - FIN: done=1 for exactly one cycle; busy=0; return to IDLE.
- raddr is driven combinationally from the pointer register. rdata is captured into the skid buffer on the cycle after issue.
- Throughput: 1 sample/clk with m_ready held high. First m_valid appears 2 cycles after the start cycle (latch cycle, then read cycle).
- Stream rules:
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - Samples are emitted in address order with no loss or duplication under arbitrary m_ready patterns.
- start while busy is ignored; start_addr and num_samples are not re-sampled.
- num_samples = 2**ADDR_WIDTH reads every location exactly once, ending at start_addr-1.

Optional Feature:
- Macro: SB_RAM_READER_DECIM_EN.
- Defined: adds input `decim [ADDR_WIDTH-1:0]`, latched at start. The pointer advances by decim+1 per issue, modulo depth; num_samples still counts emitted samples.
- Undefined: port absent; step fixed at 1.

Decomposition:
- Shared package/defines:
  - FSM state encoding: IDLE=0, RUN=1, FLUSH=2, FIN=3.
  - Default ADDR_WIDTH and DATA_WIDTH.
- Sub-module: sb_skid_buffer. It is a 2-entry valid/ready FIFO parameterized by DATA_WIDTH, with push, data_in, count, m_* outputs and no overflow protection. The reader's credit logic guarantees it never overflows. It is reusable by other stream blocks.

Test Plan:
- Preload RAM[i]=i. Apply start with start_addr=0x010, num_samples=4, m_ready=1 -> m_data sequence 0x10,0x11,0x12,0x13 on consecutive cycles; first m_valid at start+2; done pulses once; busy back to 0.
- Wrap: start_addr=0x1FE, num_samples=4 -> addresses 0x1FE,0x1FF,0x000,0x001; data 0xFE,0xFF,0x00,0x01.
- Backpressure: num_samples=16, m_ready toggling in a random pattern including 5-cycle stalls -> exactly 16 handshakes, in order, m_data stable during every stall, no more than 2 reads outstanding.
- Edge counts: num_samples=0 -> no m_valid, done pulse 2 cycles after start. num_samples=512 from 0x100 -> 512 samples, the last being RAM[0x0FF].
- Abort and re-entry: a second start mid-transfer is ignored. Asserting rst after 3 of 10 samples -> all outputs 0 immediately, no done pulse. A new start after release runs cleanly.
- With SB_RAM_READER_DECIM_EN, decim=3, start_addr=0, num_samples=4 -> data 0x00,0x04,0x08,0x0C.
